// File: rtl/display_scheduler.sv
// display_scheduler
// Rotates up to four 32-bit source words onto a hex display. In auto mode
// each enabled source is shown for DWELL cycles, then the next enabled
// source (upward, wrapping 3->0) is selected. A pulse on i_next advances
// immediately, and i_hold freezes both the selection and the displayed word.
//
// Ports:
//   i_clk              system clock, rising edge
//   i_rst_n            asynchronous active-low reset
//   i_en[3:0]          per-source enable
//   i_data0..i_data3   source words
//   i_next             single-cycle pulse: advance now
//   i_hold             level: freeze selection and displayed word
//   o_data[31:0]       registered word for the display
//   o_sel[1:0]         index of the source being shown
//   o_blank            high when no source is enabled
//   o_update           one-cycle pulse in the first cycle of a new o_sel
module display_scheduler #(
    parameter int unsigned DWELL = 32'd50000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_en,
    input  logic [31:0] i_data0,
    input  logic [31:0] i_data1,
    input  logic [31:0] i_data2,
    input  logic [31:0] i_data3,
    input  logic        i_next,
    input  logic        i_hold,
    output logic [31:0] o_data,
    output logic [1:0]  o_sel,
    output logic        o_blank,
    output logic        o_update
);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        HOLD
    } state_t;

    localparam logic [31:0] LAST = 32'(DWELL - 1);

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] words [4];
    logic [1:0]  first_sel;
    logic [1:0]  next_sel;
    logic        advance;

    assign words[0] = i_data0;
    assign words[1] = i_data1;
    assign words[2] = i_data2;
    assign words[3] = i_data3;

    // Lowest enabled index, used when leaving IDLE.
    always_comb begin
        logic found;
        first_sel = 2'd0;
        found     = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (!found && i_en[k]) begin
                first_sel = 2'(k);
                found     = 1'b1;
            end
        end
    end

    // Next enabled index strictly after o_sel; offset 4 wraps back onto
    // o_sel itself, so a lone enabled source selects itself.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        next_sel = o_sel;
        found    = 1'b0;
        idx      = o_sel;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = o_sel + 2'(k);
            if (!found && i_en[idx]) begin
                next_sel = idx;
                found    = 1'b1;
            end
        end
    end

    // Expiry and i_next collapse into one advance; a disabled current
    // source also forces one.
    assign advance = i_next || (cnt == LAST) || !i_en[o_sel];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            o_data   <= '0;
            o_sel    <= 2'd0;
            o_blank  <= 1'b1;
            o_update <= 1'b0;
        end else begin
            o_update <= 1'b0;
            if (i_en == '0) begin
                // o_sel deliberately retained
                state   <= IDLE;
                o_blank <= 1'b1;
                o_data  <= '0;
                cnt     <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state    <= SHOW;
                        o_sel    <= first_sel;
                        o_data   <= words[first_sel];
                        o_update <= 1'b1;
                        o_blank  <= 1'b0;
                        cnt      <= '0;
                    end
                    SHOW: begin
                        if (i_hold) begin
                            state <= HOLD;
                        end else if (advance) begin
                            cnt      <= '0;
                            o_sel    <= next_sel;
                            o_data   <= words[next_sel];
                            o_update <= (next_sel != o_sel);
                        end else begin
                            cnt    <= cnt + 32'd1;
                            o_data <= words[o_sel];
                        end
                    end
                    HOLD: begin
                        if (!i_hold) begin
                            // Counter resumes without stepping on the return edge.
                            state <= SHOW;
                            if (!i_en[o_sel]) begin
                                cnt      <= '0;
                                o_sel    <= next_sel;
                                o_data   <= words[next_sel];
                                o_update <= (next_sel != o_sel);
                            end else begin
                                o_data <= words[o_sel];
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter DWELL, default 50000000, number of clock cycles each source is shown in auto mode (legal range 2..2^32-1).
REQ-002 i_clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_en  input  4  per-source enable; bit k set means source k takes part in the rotation.
REQ-005 i_data0..i_data3  input  32 each  source words (e.g. PC, a0, instruction, debug).
REQ-006 i_next  input  1  single-cycle pulse: advance to the next enabled source now.
REQ-007 i_hold  input  1  level: freeze the selection and the displayed word.
REQ-008 o_data  output  32  word driven to the hex display block, registered.
REQ-009 o_sel  output  2  index of the source currently shown.
REQ-010 o_blank  output  1  high when no source is enabled; display logic forces all digits off.
REQ-011 o_update  output  1  one-cycle pulse in the cycle o_sel takes a new value.

Function
REQ-012 States SHALL be IDLE, SHOW and HOLD, held in an explicit state register.
REQ-013 IDLE: o_blank=1, o_data=0, dwell counter=0; go to SHOW when i_en!=0, selecting the lowest enabled index and pulsing o_update.
REQ-014 SHOW: dwell counter increments each cycle; on reaching DWELL-1 it clears and the selection advances.
REQ-015 Advance: next enabled index strictly after o_sel, searched upward with wrap 3->0; the search SHALL complete in one cycle.
REQ-016 Advance with only the current source enabled: o_sel unchanged, counter cleared, o_update not pulsed.
REQ-017 i_next in SHOW: advance in the same edge, counter cleared; coincidence with dwell expiry causes exactly one advance.
REQ-018 Current source's i_en bit dropping in SHOW: advance on the next edge as in REQ-015; if i_en becomes 0, go to IDLE instead.
REQ-019 i_en=0 in any state: go to IDLE on the next edge, o_sel retains its value.
REQ-020 SHOW with i_hold=1: go to HOLD; counter frozen, o_data frozen, i_next ignored.
REQ-021 HOLD with i_hold=0: return to SHOW, counter resumes from its frozen value; if the held source became disabled, advance on the return edge.
REQ-022 o_data SHALL equal the selected source word sampled one cycle earlier (latency 1) in SHOW, including the first cycle after a selection change.
REQ-023 o_update high SHALL coincide with the first cycle of the new o_sel value.
REQ-024 Dwell counter SHALL be 32 bits and never exceed DWELL-1.

Reset
REQ-025 Asynchronous assertion of i_rst_n=0 SHALL immediately force: state IDLE, o_data=0, o_sel=0, o_blank=1, o_update=0, counter=0.
REQ-026 After deassertion the first edge SHALL evaluate IDLE normally (REQ-013); reset mid-dwell or mid-hold discards all progress.

Verification (DWELL=4)
REQ-027 i_en=4'b1011, data=0x11,0x22,0x33,0x44 -> o_sel sequence 0,1,3,0 each held 4 cycles, o_update pulsed at each change, o_data tracks one cycle late.
REQ-028 i_en=4'b0101, i_next pulsed in the cycle dwell expires at o_sel=0 -> o_sel=2 once (not 0), counter restarts.
REQ-029 i_hold=1 at counter=2 on source 1 for 10 cycles while i_data1 changes -> o_data and o_sel unchanged; after release source 1 shown 2 more cycles.
REQ-030 i_en drops from 4'b0010 to 0 -> IDLE next edge, o_blank=1, o_data=0; i_en=4'b1000 -> o_sel=3, o_update pulse.
REQ-031 i_rst_n pulsed low between clock edges during SHOW on source 2 -> outputs reach reset values without a clock edge; rotation restarts from lowest enabled index.
REQ-032 i_en=4'b0100 only -> o_sel stays 2 indefinitely, o_update never pulses after entry.
